// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell; purely combinational datapath of the serial adder.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sout,
  output logic cout
);

  assign sout = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, one bit per clock, LSB first.
// The result registers are loaded on the edge that enters DONE. This makes
// sum/cout change in the same cycle that done is high.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] sum_sr;   // upper bits of the partial result; the LSB falls out
  logic [WIDTH-1:0] sum_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_sout, fa_cout;

  serial_adder_fa u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sout (fa_sout),
    .cout (fa_cout)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign sum_nx = {fa_sout, sum_sr};
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, serial shift, carry, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_nx[WIDTH-1:1];
          carry  <= fa_cout;
          // Saturate rather than wrap; the count is reloaded on the next start
          if (!last) cnt <= cnt + 1'b1;
          if (last) begin
            sum  <= sum_nx;
            cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus a random sweep
// against a + b + cin computed with plain arithmetic.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_chk = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One addition: pulse start, wait (bounded) for done, check result, latency,
  // busy length and that done is a single pulse. inj>0 pulses start again
  // with other operands in that cycle of the operation.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input int inj);
    logic [W:0] e;
    int lat, bcnt;
    bit seen;
    e = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      if (i > 1) @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        seen = 1'b1;
        lat  = i;
        chk("sum", 32'(sum), 32'(e[W-1:0]));
        chk("cout", 32'(cout), 32'(e[W]));
      end
      if (inj != 0 && i == inj) begin
        start = 1'b1; a = 8'h10; b = 8'h10;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(W + 1));
    chk("busy_len", 32'(bcnt), 32'(W + 1));
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("sum_hold", 32'(sum), 32'(e[W-1:0]));
  endtask

  initial begin
    int dt[$];
    int bad, lastd;
    bit any;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(8'h03, 8'h05, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 0);
    // Start again three cycles in: must be ignored
    do_op(8'h21, 8'h42, 1'b0, 3);

    // Reset mid-SHIFT: outputs clear at once, no done afterwards
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    any = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) any = 1'b1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) any = 1'b1;
    end
    chk("mid_rst_quiet", 32'(any), 32'd0);
    do_op(8'h7F, 8'h01, 1'b0, 0);

    // start held high: done every W+2 cycles with sum stable between pulses
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b1; start = 1'b1;
    bad = 0;
    for (int i = 1; i <= 60 && dt.size() < 3; i++) begin
      @(negedge clk);
      if (done) dt.push_back(i);
      if (dt.size() > 0 && (sum !== 8'h04 || cout !== 1'b0)) bad++;
    end
    start = 1'b0;
    chk("cont_pulses", 32'(dt.size()), 32'd3);
    lastd = (dt.size() > 0) ? dt[0] : 0;
    for (int k = 1; k < dt.size(); k++) begin
      chk("cont_period", 32'(dt[k] - lastd), 32'(W + 2));
      lastd = dt[k];
    end
    chk("cont_hold", 32'(bad), 32'd0);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    chk("cont_drain", 32'(busy), 32'd0);

    // Random sweep
    for (int n = 0; n < 1000; n++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
